// File: rtl/grade_average_unit_pkg.sv
// Shared constants for the serial grade averager: FSM encodings, default widths
// and the fixed divisor used by the iterative divide stage.
package grade_average_unit_pkg;

  localparam logic [1:0] ST_COLLECT = 2'd0;
  localparam logic [1:0] ST_DIVIDE  = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;

  localparam int DEFAULT_W              = 4;
  localparam int DEFAULT_PASS_THRESHOLD = 6;
  localparam int DIVISOR                = 3;

endpackage

// File: rtl/grade_average_unit_div3_iter.sv
// Subtract-by-3 divider: load captures the dividend, then each enabled cycle
// removes one divisor until the working remainder drops below it.
module div3_iter
  import grade_average_unit_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W+1:0] sum,
  input  logic         enable,
  output logic [W-1:0] quotient,
  output logic [1:0]   remainder,
  output logic         done
);

  localparam logic [W+1:0] DIV_C = (W+2)'(DIVISOR);

  logic [W+1:0] r_rem;
  logic [W-1:0] r_quot;
  logic         w_below;

  assign w_below = (r_rem < DIV_C);

  // ---- iteration stage: clear beats load, load beats a subtract step ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem  <= '0;
      r_quot <= '0;
    end else if (clr) begin
      r_rem  <= '0;
      r_quot <= '0;
    end else if (load) begin
      r_rem  <= sum;
      r_quot <= '0;
    end else if (enable && !w_below) begin
      r_rem  <= r_rem - DIV_C;
      r_quot <= r_quot + W'(1);
    end
  end

  // Once below the divisor the remainder is at most 2, so two bits carry it out.
  assign quotient  = r_quot;
  assign remainder = r_rem[1:0];
  assign done      = w_below;

endmodule

// File: rtl/grade_average_unit.sv
// Serial grade averager: collects three grades over a valid/ready stream,
// divides their sum by 3 iteratively and offers avg/rem/pass downstream.
module grade_average_unit
  import grade_average_unit_pkg::*;
#(
  parameter int W              = DEFAULT_W,
  parameter int PASS_THRESHOLD = DEFAULT_PASS_THRESHOLD
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         abort,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] grade_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] avg,
  output logic [1:0]   rem,
  output logic         pass,
  output logic [1:0]   grade_count
);

  localparam logic [W-1:0] PASS_TH = W'(PASS_THRESHOLD);

  logic [1:0]   r_state;
  logic [1:0]   w_state_next;
  logic [W+1:0] r_sum;
  logic [1:0]   r_count;
  logic [W-1:0] r_avg;
  logic [1:0]   r_rem;
  logic         r_pass;

  logic         w_accept;
  logic         w_consume;
  logic         w_third;
  logic         w_finish;
  logic [W+1:0] w_sum_acc;
  logic         w_div_en;
  logic [W-1:0] w_div_quot;
  logic [1:0]   w_div_rem;
  logic         w_div_done;

  // abort outranks both handshakes, so a grade or consume in that cycle is lost
  assign w_accept  = in_valid && in_ready && !abort;
  assign w_consume = out_valid && out_ready && !abort;
  assign w_third   = w_accept && (r_count == 2'd2);
  assign w_sum_acc = r_sum + {2'b00, grade_in};
  assign w_div_en  = (r_state == ST_DIVIDE);
  assign w_finish  = w_div_en && w_div_done && !abort;

  div3_iter #(.W(W)) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (abort),
    .load      (w_third),
    .sum       (w_sum_acc),
    .enable    (w_div_en),
    .quotient  (w_div_quot),
    .remainder (w_div_rem),
    .done      (w_div_done)
  );

  // ---- FSM state register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_COLLECT;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_COLLECT: if (w_third)    w_state_next = ST_DIVIDE;
      ST_DIVIDE:  if (w_div_done) w_state_next = ST_DONE;
      ST_DONE:    if (out_ready)  w_state_next = ST_COLLECT;
      default:                    w_state_next = ST_COLLECT;
    endcase
    if (abort) w_state_next = ST_COLLECT;
  end

  always_comb begin
    in_ready  = (r_state == ST_COLLECT);
    out_valid = (r_state == ST_DONE);
  end

  // ---- accumulator stage ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum   <= '0;
      r_count <= '0;
    end else if (abort) begin
      r_sum   <= '0;
      r_count <= '0;
    end else if (w_accept) begin
      r_sum   <= w_sum_acc;
      r_count <= w_third ? 2'd0 : r_count + 2'd1;
    end else if (w_consume) begin
      r_sum   <= '0;
    end
  end

  // ---- result stage: captured once, held through backpressure and after ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_avg  <= '0;
      r_rem  <= '0;
      r_pass <= 1'b0;
    end else if (w_finish) begin
      r_avg  <= w_div_quot;
      r_rem  <= w_div_rem;
      r_pass <= (w_div_quot >= PASS_TH);
    end
  end

  assign avg         = r_avg;
  assign rem         = r_rem;
  assign pass        = r_pass;
  assign grade_count = r_count;

endmodule

// File: doc/grade_average_unit.md
Name: grade_average_unit

Overview:
Sequential counterpart to the combinational average comparator. It accepts three 4-bit grades, one per handshake on a valid/ready input stream. It sums them and divides the sum by 3 with an iterative subtract-by-3 divider. It then presents the average, the remainder and a pass flag on a valid/ready output stream. It sits between the grade-entry front end and the display/result logic and replaces three parallel grade buses with one serial port.

Parameters:
- W, 4, grade width in bits; the sum is W+2 bits wide.
- PASS_THRESHOLD, 6, minimum integer average that sets pass.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- abort  in  1  synchronous clear of the current computation.
- in_valid  in  1  grade_in is valid.
- in_ready  out  1  block accepts a grade this cycle.
- grade_in  in  W  grade, 0..2^W-1; the full range is accepted with no clamping.
- out_valid  out  1  result is valid.
- out_ready  in  1  consumer takes the result.
- avg  out  W  floor(sum/3).
- rem  out  2  sum mod 3.
- pass  out  1  1 when avg >= PASS_THRESHOLD.
- grade_count  out  2  grades accepted so far in the current set, 0..2.

Behaviour:
- States: COLLECT, DIVIDE, DONE. Encode as 2-bit localparams.
- Reset (rst_n=0, asynchronous):
  - state=COLLECT.
  - sum=0, grade_count=0, quotient=0, remainder register=0.
  - avg=0, rem=0, pass=0, out_valid=0.
  - in_ready=1; it is decoded from state and is high during reset.
- in_ready = (state==COLLECT). out_valid = (state==DONE), registered via state.
- COLLECT:
  - A grade is accepted on an edge with in_valid && in_ready: sum += grade_in, grade_count++.
  - Gaps with in_valid=0 are allowed and change nothing.
  - When the 3rd grade is accepted (edge E0): sum is loaded into the working remainder with quotient=0, grade_count returns to 0, next state is DIVIDE.
- DIVIDE: each edge does the following.
  - If working remainder >= 3: subtract 3 and increment quotient.
  - Else: latch avg=quotient, rem=working remainder, pass=(quotient>=PASS_THRESHOLD); next state is DONE.
- Latency: out_valid rises q+1 edges after E0, where q=floor(sum/3). The minimum is 1 (sum<3); the maximum is 16 (sum=45).
- DONE:
  - avg, rem and pass are held stable while out_valid=1 && out_ready=0.
  - The result is consumed on an edge with out_valid && out_ready; next state is COLLECT and sum is cleared.
  - avg, rem and pass keep their last values after consumption and are valid only while out_valid=1.
  - The first new grade can be accepted on the edge after consumption. There is no same-cycle accept.
- in_valid outside COLLECT is ignored. The upstream stream must hold its data, and nothing is lost, because in_ready=0.
- abort (synchronous, any state):
  - Next state is COLLECT; sum, grade_count, quotient and working remainder are cleared; out_valid drops on that edge.
  - A partially collected set or an unconsumed result is discarded.
  - abort has priority over a simultaneous in_valid accept or out_ready consume. The grade in that cycle is dropped and is not counted.
- Width rules:
  - The sum register is W+2 bits and does not overflow (3*(2^W-1)).
  - The quotient fits in W bits.
  - Comparisons are unsigned.
- Reset asserted mid-DIVIDE or mid-DONE returns immediately to the reset values above, with no partial output.

Decomposition:
- Shared include/package holds:
  - state localparams (COLLECT/DIVIDE/DONE);
  - default W and PASS_THRESHOLD;
  - the divisor constant 3.
- One natural sub-module, div3_iter, holds the subtract-by-3 datapath:
  - inputs: load, sum, enable;
  - outputs: quotient, remainder, done.
- The top level keeps the handshake FSM, the accumulator and the result registers.

Test Plan:
- Grades 7, 8, 6 with back-to-back in_valid and out_ready=1: avg=7, rem=0, pass=1. out_valid rises 8 edges after the 3rd accept and stays high 1 cycle.
- Grades 4, 5, 5 with one-cycle in_valid gaps between grades: avg=4, rem=2, pass=0, out_valid after 5 edges. grade_count steps 0→1→2→0.
- Grades 15, 15, 15: avg=15, rem=0, pass=1, 16-edge latency. Grades 0, 0, 0: avg=0, pass=0, 1-edge latency. Grades 6, 6, 6: avg=6, pass=1, which checks the threshold boundary.
- Backpressure: result 5, 7, 3 (avg=5, rem=0, pass=0) with out_ready=0 for 6 cycles while in_valid=1 is driven.
  - Required: avg/rem/pass stable, in_ready=0, no grade accepted.
  - After out_ready=1, one consume, then in_ready=1 on the next cycle.
- abort:
  - Abort after grades 9, 9, asserted together with an in_valid for a third grade of 9. Required: that grade is dropped, grade_count=0, then grades 1, 1, 1 give avg=1, pass=0.
  - Abort during DIVIDE and during DONE: out_valid low on the next edge, in_ready=1.
- Reset mid-DIVIDE (rst_n low for 1 cycle, asynchronously): all outputs at reset values immediately. A following set 10, 10, 10 gives avg=10, pass=1.
